// File: rtl/multi_channel_protection.sv
// Multi-channel over-threshold protection: per-channel debounce, trip/retry/lockout FSM.
// Define PROT_FIRST_FAULT_EN to capture the first-faulting channel index and sample.
module multi_channel_protection #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int FAULT_CNT   = 10,
  parameter int RETRY_DELAY = 100,
  parameter int MAX_RETRY   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] meas,
  input  logic [NUM_CH*DATA_WIDTH-1:0] thr_hi,
  input  logic [NUM_CH*DATA_WIDTH-1:0] thr_lo,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic                         fault_clear,
  output logic                         shutdown,
  output logic [NUM_CH-1:0]            fault_vec,
  output logic [1:0]                   state,
  output logic [3:0]                   retry_cnt,
  output logic [3:0]                   first_ch,
  output logic [DATA_WIDTH-1:0]        first_val
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRIP    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [7:0]  FAULT_CNT_L = 8'(FAULT_CNT);
  localparam logic [15:0] DELAY_LAST  = 16'(RETRY_DELAY - 1);
  localparam logic [3:0]  MAX_RETRY_L = 4'(MAX_RETRY);

  logic [7:0]        cnt_reg  [NUM_CH];
  logic [7:0]        cnt_next [NUM_CH];
  logic [NUM_CH-1:0] fault_vec_reg;
  logic [NUM_CH-1:0] fault_next;

  state_t state_reg, state_next;
  logic [3:0]  retry_reg, retry_next;
  logic [15:0] timer_reg, timer_next;
  logic        shutdown_reg, shutdown_next;
  logic        any_fault;

  // Per-channel debounce counter and flag
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [DATA_WIDTH-1:0] smp, hi, lo;
      logic [7:0] c_n;
      logic       f_n;

      assign smp = meas[gi*DATA_WIDTH +: DATA_WIDTH];
      assign hi  = thr_hi[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lo  = thr_lo[gi*DATA_WIDTH +: DATA_WIDTH];

      always_comb begin
        c_n = cnt_reg[gi];
        if (enable && sample_valid) begin
          if (smp > hi) begin
            if (cnt_reg[gi] != FAULT_CNT_L) c_n = cnt_reg[gi] + 8'd1;
          end else if (smp < lo) begin
            if (cnt_reg[gi] != 8'd0) c_n = cnt_reg[gi] - 8'd1;
          end
        end
        f_n = fault_vec_reg[gi];
        if (c_n == FAULT_CNT_L)  f_n = 1'b1;
        else if (c_n == 8'd0)    f_n = 1'b0;
        // Masking overrides everything, even while disabled
        if (ch_mask[gi]) begin
          c_n = 8'd0;
          f_n = 1'b0;
        end
      end

      assign cnt_next[gi]   = c_n;
      assign fault_next[gi] = f_n;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_reg[i] <= 8'd0;
      fault_vec_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_reg[i] <= cnt_next[i];
      fault_vec_reg <= fault_next;
    end
  end

  assign any_fault = |fault_vec_reg;

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    timer_next = timer_reg;
    if (enable) begin
      case (state_reg)
        ST_RUN: begin
          if (fault_clear) retry_next = 4'd0;
          if (any_fault)   state_next = ST_TRIP;
        end
        ST_TRIP: begin
          if (!any_fault) begin
            if (retry_reg == MAX_RETRY_L) begin
              state_next = ST_LOCKOUT;
            end else begin
              state_next = ST_WAIT;
              timer_next = 16'd0;
              retry_next = (retry_reg == 4'hF) ? retry_reg : retry_reg + 4'd1;
            end
          end
        end
        ST_WAIT: begin
          if (any_fault) begin
            state_next = ST_TRIP;
            timer_next = 16'd0;
          end else if (timer_reg == DELAY_LAST) begin
            state_next = ST_RUN;
            timer_next = 16'd0;
          end else begin
            timer_next = timer_reg + 16'd1;
          end
        end
        ST_LOCKOUT: begin
          if (fault_clear && !any_fault) begin
            state_next = ST_RUN;
            retry_next = 4'd0;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
    // Registered so the power stage reacts on the same edge the state changes
    shutdown_next = !enable || (state_next != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      retry_reg    <= 4'd0;
      timer_reg    <= 16'd0;
      shutdown_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      retry_reg    <= retry_next;
      timer_reg    <= timer_next;
      shutdown_reg <= shutdown_next;
    end
  end

`ifdef PROT_FIRST_FAULT_EN
  logic [3:0]            low_idx;
  logic [DATA_WIDTH-1:0] low_val;
  logic                  capture;
  logic [3:0]            first_ch_reg;
  logic [DATA_WIDTH-1:0] first_val_reg;

  // Descending scan so the lowest faulting index wins
  always_comb begin
    low_idx = 4'd0;
    low_val = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fault_vec_reg[i]) begin
        low_idx = 4'(i);
        low_val = meas[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign capture = enable && (state_reg == ST_RUN) && any_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_ch_reg  <= 4'd0;
      first_val_reg <= '0;
    end else if (capture) begin
      first_ch_reg  <= low_idx;
      first_val_reg <= low_val;
    end
  end

  assign first_ch  = first_ch_reg;
  assign first_val = first_val_reg;
`else
  assign first_ch  = 4'd0;
  assign first_val = '0;
`endif

  assign shutdown  = shutdown_reg;
  assign fault_vec = fault_vec_reg;
  assign state     = state_reg;
  assign retry_cnt = retry_reg;

endmodule

// File: doc/multi_channel_protection.md
MULTI_CHANNEL_PROTECTION -- requirements
Module: multi_channel_protection

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning signed Q16.16 sample width.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning monitored channel count (1..16).
REQ-003 SHALL have parameter FAULT_CNT, default 10, meaning debounce count to declare a channel fault (1..255).
REQ-004 SHALL have parameter RETRY_DELAY, default 100, meaning auto-restart wait in clk cycles (1..65535).
REQ-005 SHALL have parameter MAX_RETRY, default 3, meaning auto-restarts allowed before lockout (0..15).
REQ-006 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; one clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  monitor enable; low forces safe state.
- sample_valid  in  1  meas qualifier; counters update only when high.
- meas  in  NUM_CH*DATA_WIDTH  packed signed samples, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- thr_hi  in  NUM_CH*DATA_WIDTH  per-channel trip thresholds, same packing.
- thr_lo  in  NUM_CH*DATA_WIDTH  per-channel release thresholds, same packing; thr_lo <= thr_hi.
- ch_mask  in  NUM_CH  1 = channel ignored.
- fault_clear  in  1  single-cycle operator clear.
- shutdown  out  1  power-stage disable.
- fault_vec  out  NUM_CH  per-channel debounced fault flags.
- state  out  2  RUN=0, TRIP=1, WAIT=2, LOCKOUT=3.
- retry_cnt  out  4  auto-restarts consumed.
- first_ch  out  4  index of first-faulting channel.
- first_val  out  DATA_WIDTH  sample of first-faulting channel.

Function
REQ-007 Per channel, on a sample_valid edge SHALL: increment saturating counter at FAULT_CNT if meas > thr_hi (signed); decrement saturating at 0 if meas < thr_lo; hold otherwise.
REQ-008 fault_vec[i] SHALL set on the edge its counter becomes FAULT_CNT and clear on the edge it becomes 0; otherwise it holds.
REQ-009 A masked channel SHALL have its counter and fault_vec bit forced to 0 on the next edge.
REQ-010 RUN: shutdown=0; if fault_vec != 0, SHALL enter TRIP next edge, shutdown=1 on that edge (one cycle after fault_vec).
REQ-011 TRIP: shutdown=1; when fault_vec == 0, SHALL enter LOCKOUT if retry_cnt == MAX_RETRY, else WAIT with retry_cnt+1.
REQ-012 WAIT: shutdown=1; SHALL count RETRY_DELAY cycles then enter RUN, deasserting shutdown on that edge; any fault_vec != 0 SHALL return to TRIP, timer reset.
REQ-013 LOCKOUT: shutdown=1; fault_clear SHALL enter RUN and zero retry_cnt only if fault_vec == 0; otherwise ignored.
REQ-014 fault_clear in RUN SHALL zero retry_cnt; in TRIP/WAIT ignored.
REQ-015 enable=0 SHALL force shutdown=1 and hold state, counters, timer, retry_cnt; on return, shutdown follows the held state next edge.
REQ-016 Simultaneous faults on several channels at RUN->TRIP: first_ch SHALL record the lowest index.
REQ-017 retry_cnt SHALL saturate at 15; MAX_RETRY=0 SHALL give lockout on first trip.

Reset
REQ-018 rst high SHALL immediately set: counters 0, fault_vec 0, state RUN, shutdown 0, retry_cnt 0, timer 0, first_ch 0, first_val 0; reset mid-WAIT/LOCKOUT discards history.

Configuration
REQ-019 Macro PROT_FIRST_FAULT_EN defined: first_ch/first_val SHALL capture on each RUN->TRIP edge and hold until the next one or reset.
REQ-020 Macro PROT_FIRST_FAULT_EN undefined: first_ch and first_val SHALL be constant 0; no capture registers; ports unchanged.

Verification (NUM_CH=4, FAULT_CNT=4, RETRY_DELAY=8, MAX_RETRY=2; thr_hi=60.0, thr_lo=55.0 all channels)
REQ-021 ch2 = 0x003D_0000 for 4 valid samples -> fault_vec=0100 on 4th edge, state=TRIP and shutdown=1 next edge; with macro first_ch=2, first_val=0x003D_0000.
REQ-022 ch0 = 0x003A_0000 (in band) after 3 over samples -> counter holds 3, no fault; one more over sample -> fault.
REQ-023 Trip then ch2 to 50.0 for 4 samples -> WAIT, retry_cnt=1; shutdown drops exactly 8 cycles later.
REQ-024 Three trip/release cycles -> third release enters LOCKOUT; fault_clear with fault present ignored; without -> RUN, retry_cnt=0.
REQ-025 ch1,ch3 over on the same samples -> fault_vec=1010, first_ch=1; ch_mask=1010 -> both bits cleared next edge.
REQ-026 enable=0 during WAIT -> shutdown=1, timer frozen; rst pulse mid-TRIP -> all outputs to REQ-018 values immediately.
